issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Parametrised successor to the dual-issue combinational hazard unit.
- Tracks in-flight register writes across LANES issue slots with per-register countdowns, so it supports variable-latency producers (ALU, load, multiply/divide).
- Decides in-order issue grants in Decode and detects RAW and WAW hazards, both against in-flight instructions and within the issue group.
- Clears speculative entries on a branch flush and counts stall cycles.

Parameters:
- LANES, 2, issue width; lane 0 is oldest.
- NREGS, 32, architectural registers.
- REGW, 5, register index width (clog2 NREGS).
- LATW, 3, latency/countdown width; max latency 2^LATW-1.
- FLUSH_AGE, 2, entries younger than this many cycles since issue are killed by flush.
- CNTW, 32, stall counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  LANES  instruction present in Decode lane
- id_rs  in  LANES*REGW  source A per lane
- id_rt  in  LANES*REGW  source B per lane
- id_use_rt  in  LANES  lane reads rt (0 for immediate forms)
- id_rd  in  LANES*REGW  destination per lane
- id_we  in  LANES  lane writes rd
- id_lat  in  LANES*LATW  cycles until result forwardable+1 (ALU=1, lw=2, mul=4)
- flush  in  1  misprediction kill from Execute
- issue_grant  out  LANES  lane advances to Execute this cycle
- stall  out  1  some valid lane not granted; holds Fetch/Decode
- busy_vec  out  NREGS  per-register pending-write flag
- stall_count  out  CNTW  saturating count of stall cycles

Behaviour:
- State per register r: busy[r], rem[r] (LATW), age[r] (LATW, saturating). Register 0 is never busy; writes to r0 are ignored.
- Reset (async, reset_n=0): all busy/rem/age = 0, stall_count = 0. busy_vec = 0 immediately. issue_grant is combinational from inputs against an empty board.
- id_lat = 0 is treated as 1.
- Source ready: src==0 || !busy[src] || rem[src]==1. rem==1 means the result is forwardable next cycle, so a lat=1 producer imposes no bubble and a lat=2 load imposes exactly 1 bubble.
- Lane i is eligible when all of:
  - id_valid[i];
  - rs is ready; rt is ready if id_use_rt[i];
  - no lower lane j with id_valid[j] && id_we[j] && rd_j!=0 && rd_j matches rs_i (or rt_i when used);
  - WAW check, if id_we[i] && rd_i!=0: busy[rd_i] implies rem[rd_i] <= lat_i, and no lower valid lane writes the same rd.
- In-order grant: issue_grant[i] = eligible[i] && every lower lane is granted or invalid. An invalid lane never blocks higher lanes.
- stall = OR over i of (id_valid[i] && !issue_grant[i]).
- flush=1 forces issue_grant = 0 and stall = 0 in that cycle.
- Sequential update each clock:
  - For busy entries: rem decrements and age increments (saturating). The entry clears when rem goes 1->0.
  - Granted lane with we && rd!=0: busy=1, rem=lat, age=0. An issue overrides a same-cycle decrement or clear of that register.
  - flush: clears every busy entry with age < FLUSH_AGE, evaluated on pre-update state. Older entries continue counting down.
  - stall_count: +1 when stall=1, saturating at all-ones.
- busy_vec is registered state.
- No other state machine; all hazard outputs are combinational from the current board state and the Decode inputs.

Test Plan:
- Reset, then lane0 add r3 (lat1), lane1 sub r4<-r3: lane1 has an intra-group RAW -> grant=01, stall=1. Next cycle lane1 re-presented alone -> grant=01 (now lane 0), stall=0, no bubble from rem==1.
- lw r5 (lat2) granted at t; at t+1 a consumer of r5 -> grant=0, stall=1, stall_count=1; at t+2 -> granted; busy_vec[5] clears after t+2.
- mul r7 (lat4) in flight with rem=3; add r7 (lat1) presented -> WAW blocks until rem<=1; a lane-1 instruction behind it is also held (in-order).
- Issue add r8 at t, flush at t+1 -> busy_vec[8]=0 at t+2, grants=0 during t+1. An entry with age>=2 survives.
- Lane0 invalid, lane1 valid and independent -> grant=10. Lanes writing r0 -> never busy, never stall.
- Force stall for 2^CNTW+ cycles (CNTW=4 variant) -> stall_count saturates at 15. Assert reset_n mid-countdown -> busy_vec=0 asynchronously.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard issue interface: per-lane instruction fields in,
// per-lane grants and the combined stall out.
interface issue_scoreboard_if #(
    parameter int LANES = 2,
    parameter int REGW  = 5,
    parameter int LATW  = 3
);
    logic [LANES-1:0]           id_valid;
    logic [LANES-1:0][REGW-1:0] id_rs;
    logic [LANES-1:0][REGW-1:0] id_rt;
    logic [LANES-1:0]           id_use_rt;
    logic [LANES-1:0][REGW-1:0] id_rd;
    logic [LANES-1:0]           id_we;
    logic [LANES-1:0][LATW-1:0] id_lat;
    logic                       flush;
    logic [LANES-1:0]           issue_grant;
    logic                       stall;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rt, id_rd, id_we, id_lat, flush,
        input  issue_grant, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rt, id_rd, id_we, id_lat, flush,
        output issue_grant, stall
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Multi-lane issue scoreboard: per-register countdowns for variable-latency
// producers, RAW/WAW checks against the board and within the issue group.
module issue_scoreboard_lane #(
    parameter int LANE  = 0,
    parameter int LANES = 2,
    parameter int NREGS = 32,
    parameter int REGW  = 5,
    parameter int LATW  = 3
) (
    input  logic [NREGS-1:0]           busy,
    input  logic [NREGS-1:0][LATW-1:0] rem,
    input  logic [LANES-1:0]           valid,
    input  logic [LANES-1:0][REGW-1:0] rs,
    input  logic [LANES-1:0][REGW-1:0] rt,
    input  logic [LANES-1:0]           use_rt,
    input  logic [LANES-1:0][REGW-1:0] rd,
    input  logic [LANES-1:0]           we,
    input  logic [LANES-1:0][LATW-1:0] lat,
    output logic                       elig
);
    // rem==1 means the value forwards next cycle, so a reader may go now
    function automatic logic src_rdy(input logic [REGW-1:0] s);
        return (s == '0) || !busy[s] || (rem[s] == LATW'(1));
    endfunction

    always_comb begin
        elig = valid[LANE];
        if (!src_rdy(rs[LANE]))
            elig = 1'b0;
        if (use_rt[LANE] && !src_rdy(rt[LANE]))
            elig = 1'b0;
        if (we[LANE] && rd[LANE] != '0 && busy[rd[LANE]] && rem[rd[LANE]] > lat[LANE])
            elig = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (j < LANE && valid[j] && we[j] && rd[j] != '0) begin
                if (rd[j] == rs[LANE])
                    elig = 1'b0;
                if (use_rt[LANE] && rd[j] == rt[LANE])
                    elig = 1'b0;
                if (we[LANE] && rd[j] == rd[LANE])
                    elig = 1'b0;
            end
        end
    end
endmodule

module issue_scoreboard #(
    parameter int LANES     = 2,
    parameter int NREGS     = 32,
    parameter int REGW      = 5,
    parameter int LATW      = 3,
    parameter int FLUSH_AGE = 2,
    parameter int CNTW      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    issue_scoreboard_if.slave dec,
    output logic [NREGS-1:0] busy_vec,
    output logic [CNTW-1:0]  stall_count
);
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0][LATW-1:0] rem;
    logic [NREGS-1:0][LATW-1:0] age;
    logic [LANES-1:0][LATW-1:0] lat_eff;
    logic [LANES-1:0]           elig;
    logic [LANES-1:0]           grant;
    logic                       stall_c;
    logic                       blocked;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            lat_eff[i] = (dec.id_lat[i] == '0) ? LATW'(1) : dec.id_lat[i];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        issue_scoreboard_lane #(
            .LANE (g),
            .LANES(LANES),
            .NREGS(NREGS),
            .REGW (REGW),
            .LATW (LATW)
        ) u_lane (
            .busy  (busy),
            .rem   (rem),
            .valid (dec.id_valid),
            .rs    (dec.id_rs),
            .rt    (dec.id_rt),
            .use_rt(dec.id_use_rt),
            .rd    (dec.id_rd),
            .we    (dec.id_we),
            .lat   (lat_eff),
            .elig  (elig[g])
        );
    end

    // In-order grant: the first valid lane that cannot go blocks everything younger
    always_comb begin
        grant   = '0;
        blocked = dec.flush;
        for (int i = 0; i < LANES; i++) begin
            grant[i] = elig[i] && !blocked;
            if (dec.id_valid[i] && !grant[i])
                blocked = 1'b1;
        end
        stall_c = !dec.flush && |(dec.id_valid & ~grant);
    end

    assign dec.issue_grant = grant;
    assign dec.stall       = stall_c;
    assign busy_vec        = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            rem         <= '0;
            age         <= '0;
            stall_count <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (busy[r]) begin
                    if ((dec.flush && int'(age[r]) < FLUSH_AGE) || rem[r] <= LATW'(1)) begin
                        busy[r] <= 1'b0;
                        rem[r]  <= '0;
                        age[r]  <= '0;
                    end else begin
                        rem[r] <= rem[r] - LATW'(1);
                        if (age[r] != '1)
                            age[r] <= age[r] + LATW'(1);
                    end
                end
            end
            // Later assignments win: a new issue overrides decrement/clear
            for (int i = 0; i < LANES; i++) begin
                if (grant[i] && dec.id_we[i] && dec.id_rd[i] != '0) begin
                    busy[dec.id_rd[i]] <= 1'b1;
                    rem[dec.id_rd[i]]  <= lat_eff[i];
                    age[dec.id_rd[i]]  <= '0;
                end
            end
            if (stall_c && stall_count != '1)
                stall_count <= stall_count + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (2 lanes, 4-bit stall counter).
module tb_issue_scoreboard;
    localparam int LANES = 2, NREGS = 32, REGW = 5, LATW = 3, CNTW = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NREGS-1:0] busy_vec;
    logic [CNTW-1:0]  stall_count;
    int               n_vec = 0;
    int               n_bad = 0;

    issue_scoreboard_if #(.LANES(LANES), .REGW(REGW), .LATW(LATW)) ifc ();

    issue_scoreboard #(
        .LANES(LANES), .NREGS(NREGS), .REGW(REGW), .LATW(LATW),
        .FLUSH_AGE(2), .CNTW(CNTW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec        (ifc),
        .busy_vec   (busy_vec),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        ifc.id_valid = '0; ifc.id_rs = '0; ifc.id_rt = '0; ifc.id_use_rt = '0;
        ifc.id_rd = '0; ifc.id_we = '0; ifc.id_lat = '0; ifc.flush = 1'b0;
    endtask

    task automatic set_lane(input int i, input int rs, input int rt, input logic urt,
                            input int rd, input logic we, input int lat);
        ifc.id_valid[i]  = 1'b1;
        ifc.id_rs[i]     = REGW'(rs);
        ifc.id_rt[i]     = REGW'(rt);
        ifc.id_use_rt[i] = urt;
        ifc.id_rd[i]     = REGW'(rd);
        ifc.id_we[i]     = we;
        ifc.id_lat[i]    = LATW'(lat);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        #2;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_vec++; if (busy_vec !== '0) begin $display("FAIL rst_busy got %h exp 0", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== '0) begin $display("FAIL rst_cnt got %0d exp 0", stall_count); n_bad++; end
        set_lane(0, 1, 2, 1, 3, 1, 1);
        set_lane(1, 3, 1, 1, 4, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL rst_grant got %b exp 01", ifc.issue_grant); n_bad++; end
        idle();
        @(posedge clk); #1;
        n_vec++; if (busy_vec !== '0) begin $display("FAIL rst_hold_busy got %h exp 0", busy_vec); n_bad++; end
        reset_n = 1'b1;
    endtask

    task automatic test_intra_raw();
        do_reset();
        set_lane(0, 1, 2, 1, 3, 1, 1);
        set_lane(1, 3, 1, 1, 4, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL raw_grant got %b exp 01", ifc.issue_grant); n_bad++; end
        n_vec++; if (ifc.stall !== 1'b1) begin $display("FAIL raw_stall got %b exp 1", ifc.stall); n_bad++; end
        cyc();
        n_vec++; if (busy_vec !== 32'h0000_0008) begin $display("FAIL raw_busy1 got %h exp 00000008", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd1) begin $display("FAIL raw_cnt1 got %0d exp 1", stall_count); n_bad++; end
        idle();
        set_lane(0, 3, 1, 1, 4, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL raw_regrant got %b exp 01", ifc.issue_grant); n_bad++; end
        n_vec++; if (ifc.stall !== 1'b0) begin $display("FAIL raw_nobubble got %b exp 0", ifc.stall); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== 32'h0000_0010) begin $display("FAIL raw_busy2 got %h exp 00000010", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd1) begin $display("FAIL raw_cnt2 got %0d exp 1", stall_count); n_bad++; end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lane(0, 1, 0, 0, 5, 1, 2);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL lu_lw got %b exp 01", ifc.issue_grant); n_bad++; end
        cyc();
        idle();
        set_lane(0, 5, 0, 1, 6, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b00) begin $display("FAIL lu_bubble got %b exp 00", ifc.issue_grant); n_bad++; end
        n_vec++; if (ifc.stall !== 1'b1) begin $display("FAIL lu_stall got %b exp 1", ifc.stall); n_bad++; end
        cyc();
        n_vec++; if (stall_count !== 4'd1) begin $display("FAIL lu_cnt got %0d exp 1", stall_count); n_bad++; end
        n_vec++; if (busy_vec !== 32'h0000_0020) begin $display("FAIL lu_busy5 got %h exp 00000020", busy_vec); n_bad++; end
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL lu_go got %b exp 01", ifc.issue_grant); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== 32'h0000_0040) begin $display("FAIL lu_clear got %h exp 00000040", busy_vec); n_bad++; end
    endtask

    task automatic test_waw();
        do_reset();
        set_lane(0, 1, 2, 1, 7, 1, 4);
        cyc();
        idle();
        set_lane(0, 1, 0, 0, 7, 1, 1);
        set_lane(1, 2, 0, 0, 9, 1, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (ifc.issue_grant !== 2'b00) begin $display("FAIL waw_hold%0d got %b exp 00", k, ifc.issue_grant); n_bad++; end
            cyc();
        end
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b11) begin $display("FAIL waw_go got %b exp 11", ifc.issue_grant); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== 32'h0000_0280) begin $display("FAIL waw_busy got %h exp 00000280", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd3) begin $display("FAIL waw_cnt got %0d exp 3", stall_count); n_bad++; end
        set_lane(0, 1, 0, 0, 10, 1, 1);
        set_lane(1, 2, 0, 0, 10, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL waw_intra got %b exp 01", ifc.issue_grant); n_bad++; end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_lane(0, 1, 0, 0, 9, 1, 7);
        cyc();
        idle();
        cyc();
        cyc();
        set_lane(0, 1, 0, 0, 8, 1, 3);
        cyc();
        idle();
        ifc.flush = 1'b1;
        set_lane(0, 1, 0, 0, 11, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b00) begin $display("FAIL fl_grant got %b exp 00", ifc.issue_grant); n_bad++; end
        n_vec++; if (ifc.stall !== 1'b0) begin $display("FAIL fl_stall got %b exp 0", ifc.stall); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== 32'h0000_0200) begin $display("FAIL fl_busy got %h exp 00000200", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd0) begin $display("FAIL fl_cnt got %0d exp 0", stall_count); n_bad++; end
        set_lane(0, 9, 0, 0, 12, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b00) begin $display("FAIL fl_survivor got %b exp 00", ifc.issue_grant); n_bad++; end
        idle();
    endtask

    task automatic test_lanes_r0();
        do_reset();
        set_lane(0, 1, 0, 0, 14, 1, 1);
        ifc.id_valid[0] = 1'b0;
        set_lane(1, 2, 0, 0, 12, 1, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b10) begin $display("FAIL ln_gap got %b exp 10", ifc.issue_grant); n_bad++; end
        n_vec++; if (ifc.stall !== 1'b0) begin $display("FAIL ln_gap_stall got %b exp 0", ifc.stall); n_bad++; end
        cyc();
        idle();
        set_lane(0, 1, 0, 0, 0, 1, 4);
        set_lane(1, 0, 0, 1, 13, 1, 0);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b11) begin $display("FAIL ln_r0 got %b exp 11", ifc.issue_grant); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== 32'h0000_2000) begin $display("FAIL ln_busy got %h exp 00002000", busy_vec); n_bad++; end
        set_lane(0, 13, 0, 0, 14, 0, 1);
        #1;
        n_vec++; if (ifc.issue_grant !== 2'b01) begin $display("FAIL ln_lat0 got %b exp 01", ifc.issue_grant); n_bad++; end
        cyc();
        idle();
        n_vec++; if (busy_vec !== '0) begin $display("FAIL ln_clear got %h exp 0", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd0) begin $display("FAIL ln_cnt got %0d exp 0", stall_count); n_bad++; end
    endtask

    task automatic test_saturate();
        do_reset();
        set_lane(0, 1, 0, 0, 10, 1, 1);
        set_lane(1, 2, 0, 0, 10, 1, 1);
        repeat (14) cyc();
        n_vec++; if (stall_count !== 4'd14) begin $display("FAIL sat_14 got %0d exp 14", stall_count); n_bad++; end
        repeat (6) cyc();
        n_vec++; if (stall_count !== 4'd15) begin $display("FAIL sat_15 got %0d exp 15", stall_count); n_bad++; end
        idle();
        set_lane(0, 1, 0, 0, 7, 1, 7);
        cyc();
        idle();
        n_vec++; if (busy_vec[7] !== 1'b1) begin $display("FAIL ar_busy got %b exp 1", busy_vec[7]); n_bad++; end
        #3 reset_n = 1'b0;
        #1;
        n_vec++; if (busy_vec !== '0) begin $display("FAIL ar_clear got %h exp 0", busy_vec); n_bad++; end
        n_vec++; if (stall_count !== 4'd0) begin $display("FAIL ar_cnt got %0d exp 0", stall_count); n_bad++; end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_intra_raw();
        test_load_use();
        test_waw();
        test_flush();
        test_lanes_r0();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
